// File: rtl/branch_predictor_if.sv
// Lookup and feedback bundle between fetch/decode (master) and the branch predictor (slave).
//  Lookup:   i_pc -> o_pc_override, o_target (same cycle)
//  Feedback: i_fb_* resolved outcome -> o_mispredict, o_redirect_pc (same cycle)
//  Perf:     o_branch_count, o_mispredict_count (registered)
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface branch_predictor_if #(
  parameter int unsigned PC_SIZE = `PC_SIZE,
  parameter int unsigned CNT_W   = 16
);
  logic [PC_SIZE-1:0] i_pc;
  logic               o_pc_override;
  logic [PC_SIZE-1:0] o_target;
  logic               i_fb_valid;
  logic               i_fb_branch;
  logic [PC_SIZE-1:0] i_fb_pc;
  logic               i_fb_predict_taken;
  logic [PC_SIZE-1:0] i_fb_predict_target;
  logic               i_fb_taken;
  logic [PC_SIZE-1:0] i_fb_target;
  logic               o_mispredict;
  logic [PC_SIZE-1:0] o_redirect_pc;
  logic [CNT_W-1:0]   o_branch_count;
  logic [CNT_W-1:0]   o_mispredict_count;

  modport master (
    output i_pc, i_fb_valid, i_fb_branch, i_fb_pc, i_fb_predict_taken,
           i_fb_predict_target, i_fb_taken, i_fb_target,
    input  o_pc_override, o_target, o_mispredict, o_redirect_pc,
           o_branch_count, o_mispredict_count
  );

  modport slave (
    input  i_pc, i_fb_valid, i_fb_branch, i_fb_pc, i_fb_predict_taken,
           i_fb_predict_target, i_fb_taken, i_fb_target,
    output o_pc_override, o_target, o_mispredict, o_redirect_pc,
           o_branch_count, o_mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
//  clk    rising-edge clock
//  n_rst  asynchronous active-low reset (clears table and perf counters)
//  bp     branch_predictor_if.slave: 0-cycle lookup, feedback/training, mispredict
//         redirect, saturating branch/mispredict performance counters
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module branch_predictor #(
  parameter int unsigned PC_SIZE = `PC_SIZE,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_SIZE - IDX_W;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [PC_SIZE-1:0] target;
    logic [1:0]         ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] fb_idx;
  entry_t           lk_e;
  entry_t           fb_e;
  logic             lk_hit;
  logic             fb_hit;
  logic             fb;
  logic             false_hit_pred;
  logic             wrong_pred;

  // Lookup and feedback read the pre-update table independently
  assign lk_idx = bp.i_pc[IDX_W-1:0];
  assign fb_idx = bp.i_fb_pc[IDX_W-1:0];
  assign lk_e   = tbl[lk_idx];
  assign fb_e   = tbl[fb_idx];
  assign lk_hit = n_rst & lk_e.valid & (lk_e.tag == bp.i_pc[PC_SIZE-1:IDX_W]);
  assign fb_hit = fb_e.valid & (fb_e.tag == bp.i_fb_pc[PC_SIZE-1:IDX_W]);

  assign bp.o_pc_override = lk_hit & lk_e.ctr[1];
  assign bp.o_target      = lk_hit ? lk_e.target : '0;

  // Mispredict: wrong direction, wrong taken target, or a non-branch fetched as taken
  assign fb             = bp.i_fb_valid & bp.i_fb_branch;
  assign wrong_pred     = (bp.i_fb_predict_taken != bp.i_fb_taken)
                        | (bp.i_fb_taken & (bp.i_fb_predict_target != bp.i_fb_target));
  assign false_hit_pred = bp.i_fb_valid & ~bp.i_fb_branch & bp.i_fb_predict_taken;
  assign bp.o_mispredict  = n_rst & ((fb & wrong_pred) | false_hit_pred);
  assign bp.o_redirect_pc = (fb & bp.i_fb_taken) ? bp.i_fb_target
                                                 : bp.i_fb_pc + PC_SIZE'(1);

  // Table training
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (fb) begin
      if (fb_hit) begin
        if (bp.i_fb_taken) begin
          if (fb_e.ctr != 2'b11) tbl[fb_idx].ctr <= fb_e.ctr + 2'd1;
          tbl[fb_idx].target <= bp.i_fb_target;
        end else if (fb_e.ctr != 2'b00) begin
          tbl[fb_idx].ctr <= fb_e.ctr - 2'd1;
        end
      end else if (bp.i_fb_taken) begin
        tbl[fb_idx] <= '{valid:  1'b1,
                         tag:    bp.i_fb_pc[PC_SIZE-1:IDX_W],
                         target: bp.i_fb_target,
                         ctr:    2'b10};
      end
    end else if (bp.i_fb_valid & fb_hit) begin
      // Non-branch hit the BTB through aliasing: drop the entry
      tbl[fb_idx].valid <= 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bp.o_branch_count     <= '0;
      bp.o_mispredict_count <= '0;
    end else begin
      if (fb && (bp.o_branch_count != '1))
        bp.o_branch_count <= bp.o_branch_count + CNT_W'(1);
      if (bp.o_mispredict && (bp.o_mispredict_count != '1))
        bp.o_mispredict_count <= bp.o_mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// against a table model keyed by full PC.
module tb_branch_predictor;

  localparam int unsigned PC_SIZE = 16;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CMAX    = (1 << CNT_W) - 1;
  localparam int unsigned PC_MOD  = 1 << PC_SIZE;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  branch_predictor_if #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) bp ();

  branch_predictor #(.PC_SIZE(PC_SIZE), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bp   (bp)
  );

  always #5 clk = ~clk;

  // Model: per-slot record of which full PC owns it, its target and counter value 0..3
  bit          m_valid [ENTRIES];
  int unsigned m_owner [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_bc, m_mc;

  function automatic void m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[pc % ENTRIES] && (m_owner[pc % ENTRIES] == pc);
  endfunction

  function automatic void m_lookup(input int unsigned pc, output bit ovr, output int unsigned tgt);
    ovr = m_hit(pc) && (m_ctr[pc % ENTRIES] >= 2);
    tgt = m_hit(pc) ? m_tgt[pc % ENTRIES] : 0;
  endfunction

  function automatic bit m_misp();
    bit fb = bp.i_fb_valid && bp.i_fb_branch;
    return (fb && ((bp.i_fb_predict_taken != bp.i_fb_taken) ||
                   (bp.i_fb_taken && (bp.i_fb_predict_target != bp.i_fb_target)))) ||
           (bp.i_fb_valid && !bp.i_fb_branch && bp.i_fb_predict_taken);
  endfunction

  function automatic int unsigned m_redirect();
    if (bp.i_fb_valid && bp.i_fb_branch && bp.i_fb_taken) return bp.i_fb_target;
    return (int'(bp.i_fb_pc) + 1) % PC_MOD;
  endfunction

  function automatic void m_update(input bit mp);
    int unsigned pc  = bp.i_fb_pc;
    int unsigned idx = pc % ENTRIES;
    bit fb   = bp.i_fb_valid && bp.i_fb_branch;
    bit fhit = m_hit(pc);
    if (fb) begin
      if (fhit) begin
        if (bp.i_fb_taken) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = bp.i_fb_target;
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (bp.i_fb_taken) begin
        m_valid[idx] = 1; m_owner[idx] = pc; m_tgt[idx] = bp.i_fb_target; m_ctr[idx] = 2;
      end
    end else if (bp.i_fb_valid && fhit) begin
      m_valid[idx] = 0;
    end
    if (fb && m_bc < CMAX) m_bc++;
    if (mp && m_mc < CMAX) m_mc++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fb(input bit v, input bit b, input int unsigned pc, input bit pt,
                        input int unsigned ptg, input bit t, input int unsigned tg);
    bp.i_fb_valid          = v;
    bp.i_fb_branch         = b;
    bp.i_fb_pc             = PC_SIZE'(pc);
    bp.i_fb_predict_taken  = pt;
    bp.i_fb_predict_target = PC_SIZE'(ptg);
    bp.i_fb_taken          = t;
    bp.i_fb_target         = PC_SIZE'(tg);
  endtask

  // Feedback carrying the prediction the model says fetch would have received
  task automatic set_fb_pred(input bit v, input bit b, input int unsigned pc,
                             input bit t, input int unsigned tg);
    bit ovr; int unsigned ptg;
    m_lookup(pc, ovr, ptg);
    set_fb(v, b, pc, ovr, ptg, t, tg);
  endtask

  task automatic idle(input int unsigned pc);
    bp.i_pc = PC_SIZE'(pc);
    set_fb(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle from a negedge: check combinational outputs, clock, check counters
  task automatic step(input string tag);
    bit ovr, mp; int unsigned tgt;
    #2;
    m_lookup(bp.i_pc, ovr, tgt);
    mp = m_misp();
    chk({tag, ":override"}, 32'(bp.o_pc_override), 32'(ovr));
    chk({tag, ":target"}, 32'(bp.o_target), tgt);
    chk({tag, ":mispredict"}, 32'(bp.o_mispredict), 32'(mp));
    if (mp) chk({tag, ":redirect"}, 32'(bp.o_redirect_pc), m_redirect());
    @(posedge clk);
    m_update(mp);
    #2;
    chk({tag, ":branch_count"}, 32'(bp.o_branch_count), m_bc);
    chk({tag, ":mispredict_count"}, 32'(bp.o_mispredict_count), m_mc);
    @(negedge clk);
  endtask

  int unsigned pool [8] = '{32'h0010, 32'h0110, 32'h0013, 32'h0023,
                            32'h00A7, 32'hFFFF, 32'h0000, 32'h1230};

  initial begin
    clk = 0;
    n_rst = 0;
    m_reset();
    bp.i_pc = 16'h0010;
    set_fb(1, 1, 16'h0010, 0, 0, 1, 16'h0040);

    // 1: held in reset
    #3;
    chk("rst:override", 32'(bp.o_pc_override), 0);
    chk("rst:target", 32'(bp.o_target), 0);
    chk("rst:mispredict", 32'(bp.o_mispredict), 0);
    chk("rst:branch_count", 32'(bp.o_branch_count), 0);
    chk("rst:mispredict_count", 32'(bp.o_mispredict_count), 0);
    @(negedge clk);
    n_rst = 1;

    // 2: first taken branch allocates
    #1;
    chk("t2:mispredict", 32'(bp.o_mispredict), 1);
    chk("t2:redirect", 32'(bp.o_redirect_pc), 32'h0040);
    step("t2_alloc");
    idle(16'h0010);
    #1;
    chk("t2:override", 32'(bp.o_pc_override), 1);
    chk("t2:target", 32'(bp.o_target), 32'h0040);
    step("t2_lookup");

    // 3: counter saturates low, one taken moves to weakly not-taken
    set_fb_pred(1, 1, 16'h0010, 0, 0); step("t3_nt1");
    set_fb_pred(1, 1, 16'h0010, 0, 0); step("t3_nt2");
    idle(16'h0010); #1; chk("t3:override_00", 32'(bp.o_pc_override), 0); step("t3_look");
    set_fb_pred(1, 1, 16'h0010, 0, 0); step("t3_nt3");
    set_fb_pred(1, 1, 16'h0010, 1, 16'h0040); step("t3_tk");
    idle(16'h0010); #1; chk("t3:override_01", 32'(bp.o_pc_override), 0); step("t3_look2");

    // 4: non-branch predicted taken through aliasing
    set_fb(1, 0, 16'h0010, 1, 16'h0040, 0, 0);
    #1;
    chk("t4:mispredict", 32'(bp.o_mispredict), 1);
    chk("t4:redirect", 32'(bp.o_redirect_pc), 32'h0011);
    step("t4_alias");
    idle(16'h0010); #1; chk("t4:miss", 32'(bp.o_target), 0); step("t4_look");

    // 5: taken target changes
    set_fb(1, 1, 16'h0010, 0, 0, 1, 16'h0040); step("t5_alloc");
    set_fb(1, 1, 16'h0010, 1, 16'h0040, 1, 16'h0050);
    #1;
    chk("t5:mispredict", 32'(bp.o_mispredict), 1);
    chk("t5:redirect", 32'(bp.o_redirect_pc), 32'h0050);
    step("t5_retarget");
    idle(16'h0010); #1; chk("t5:target", 32'(bp.o_target), 32'h0050); step("t5_look");

    // Random traffic, including same-slot lookup/feedback and counter saturation
    for (int n = 0; n < 400; n++) begin
      int unsigned pc = pool[$urandom_range(0, 7)];
      int unsigned tg = ($urandom_range(0, 2) == 0) ? ($urandom() % PC_MOD) :
                        32'h0040 + 32'h10 * $urandom_range(0, 1);
      bit v = ($urandom_range(0, 7) != 0);
      bit b = ($urandom_range(0, 3) != 0);
      bit t = $urandom_range(0, 1) != 0;
      bp.i_pc = PC_SIZE'(pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) != 0) set_fb_pred(v, b, pc, t, tg);
      else set_fb(v, b, pc, $urandom_range(0, 1) != 0, tg, t, tg);
      step("rand");
    end

    // 6: reset mid-stream
    set_fb(1, 1, 16'h0010, 0, 0, 1, 16'h0040); step("t6_b1");
    set_fb(1, 1, 16'h0023, 0, 0, 1, 16'h0080); step("t6_b2");
    set_fb_pred(1, 1, 16'h0010, 1, 16'h0040); step("t6_b3");
    bp.i_pc = 16'h0010;
    set_fb(1, 1, 16'h0023, 0, 0, 1, 16'h0099);
    #2 n_rst = 0;
    #1;
    chk("t6:branch_count", 32'(bp.o_branch_count), 0);
    chk("t6:mispredict_count", 32'(bp.o_mispredict_count), 0);
    chk("t6:override", 32'(bp.o_pc_override), 0);
    chk("t6:mispredict_rst", 32'(bp.o_mispredict), 0);
    m_reset();
    @(negedge clk);
    n_rst = 1;
    idle(16'h0010); #1; chk("t6:miss_0010", 32'(bp.o_target), 0); step("t6_look");
    idle(16'h0023); #1; chk("t6:miss_0023", 32'(bp.o_pc_override), 0); step("t6_look2");
    set_fb(1, 1, 16'hFFFF, 1, 16'h1234, 0, 0);
    #1;
    chk("t6:mispredict", 32'(bp.o_mispredict), 1);
    chk("t6:redirect_wrap", 32'(bp.o_redirect_pc), 0);
    step("t6_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
